binary_sub: RTL and testbench



---
 rtl/binary_sub.sv | 116 +++++++++++
 tb/tb_binary_sub.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/binary_sub.sv
//============================================================================
// Module   : binary_sub
// Brief    : Registered WIDTH-bit ripple-borrow subtractor, D = A - B - Cin,
//            with borrow-out Bo and a one-cycle output register stage.
//            Optional signed-overflow output ov is built only when the macro
//            BINARY_SUB_OVERFLOW_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

// One-bit full-subtractor cell: d = a - b - bin, bout is the borrow it needs.
module binary_sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Difference bit and borrow generate/propagate
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

module binary_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
`ifdef BINARY_SUB_OVERFLOW_EN
    output logic             ov,
`endif
    output logic             out_valid
);

    // Borrow chain: borrow[0] is the borrow-in, borrow[WIDTH] the borrow-out.
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff_d;
    logic             bo_d;

    logic [WIDTH-1:0] diff_q;
    logic             bo_q;
    logic             valid_q;

    assign borrow[0] = Cin;

    // Ripple of full-subtractor cells, LSB first
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            binary_sub_cell u_cell (
                .a_i    (A[i]),
                .b_i    (B[i]),
                .bin_i  (borrow[i]),
                .d_o    (diff_d[i]),
                .bout_o (borrow[i+1])
            );
        end
    endgenerate

    assign bo_d = borrow[WIDTH];

    // Capture the difference and borrow only on accepted operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q <= '0;
            bo_q   <= 1'b0;
        end else if (in_valid) begin
            diff_q <= diff_d;
            bo_q   <= bo_d;
        end
    end

    // out_valid follows in_valid by one cycle, so it marks fresh results only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
        end
    end

    assign D         = diff_q;
    assign Bo        = bo_q;
    assign out_valid = valid_q;

`ifdef BINARY_SUB_OVERFLOW_EN
    // Two's-complement overflow: operand signs differ and result sign differs from A
    logic ov_d;
    logic ov_q;

    assign ov_d = (A[WIDTH-1] ^ B[WIDTH-1]) & (A[WIDTH-1] ^ diff_d[WIDTH-1]);

    // Overflow flag is registered alongside D/Bo
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
        end else if (in_valid) begin
            ov_q <= ov_d;
        end
    end

    assign ov = ov_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_binary_sub.sv
//============================================================================
// Module   : tb_binary_sub
// Brief    : Directed self-checking bench for binary_sub (WIDTH = 4).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_binary_sub;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             out_valid;
`ifdef BINARY_SUB_OVERFLOW_EN
    logic             ov;
`endif

    int checks;
    int errors;

    binary_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .D         (D),
        .Bo        (Bo),
`ifdef BINARY_SUB_OVERFLOW_EN
        .ov        (ov),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive operands between edges, then land just after the capturing edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
        @(negedge clk);
        A        = a;
        B        = b;
        Cin      = c;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [3:0] d, input logic bo);
        chk({tag, "_D"}, {28'd0, D}, {28'd0, d});
        chk({tag, "_Bo"}, {31'd0, Bo}, {31'd0, bo});
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        logic [4:0] full;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_D", {28'd0, D}, 32'd0);
        chk("rst_Bo", {31'd0, Bo}, 32'd0);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
`ifdef BINARY_SUB_OVERFLOW_EN
        chk("rst_ov", {31'd0, ov}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Zero operands after release
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk_res("zero", 4'b0000, 1'b0);

        // Borrow cases
        step(4'b0110, 4'b1111, 1'b0, 1'b1);
        chk_res("b1", 4'b0111, 1'b1);
        step(4'b0001, 4'b1110, 1'b1, 1'b1);
        chk_res("b2", 4'b0010, 1'b1);
        step(4'b0011, 4'b1010, 1'b0, 1'b1);
        chk_res("b3", 4'b1001, 1'b1);
`ifdef BINARY_SUB_OVERFLOW_EN
        chk("b3_ov", {31'd0, ov}, 32'd1);
`endif

        // No-borrow cases
        step(4'b1111, 4'b1000, 1'b0, 1'b1);
        chk_res("nb1", 4'b0111, 1'b0);
`ifdef BINARY_SUB_OVERFLOW_EN
        chk("nb1_ov", {31'd0, ov}, 32'd0);
`endif
        step(4'b1011, 4'b1000, 1'b0, 1'b1);
        chk_res("nb2", 4'b0011, 1'b0);

        // Boundaries: A == B with Cin, and 0 - all-ones - 1
        step(4'b0101, 4'b0101, 1'b1, 1'b1);
        chk_res("eq_cin", 4'b1111, 1'b1);
        step(4'b0000, 4'b1111, 1'b1, 1'b1);
        chk_res("zero_ones", 4'b0000, 1'b1);

        // Load a nonzero result, then hold with in_valid low
        step(4'b1001, 4'b0010, 1'b0, 1'b1);
        chk_res("pre_hold", 4'b0111, 1'b0);
        step(4'b0000, 4'b0001, 1'b1, 1'b0);
        chk("hold_D", {28'd0, D}, 32'h7);
        chk("hold_Bo", {31'd0, Bo}, 32'd0);
        chk("hold_vld", {31'd0, out_valid}, 32'd0);
        step(4'b0010, 4'b1100, 1'b0, 1'b0);
        chk("hold2_D", {28'd0, D}, 32'h7);
        chk("hold2_vld", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream
        step(4'b0011, 4'b1010, 1'b0, 1'b1);
        chk_res("pre_rst", 4'b1001, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("arst_D", {28'd0, D}, 32'd0);
        chk("arst_Bo", {31'd0, Bo}, 32'd0);
        chk("arst_vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_held_D", {28'd0, D}, 32'd0);
        chk("arst_held_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back exhaustive stream
        for (int i = 0; i < 512; i++) begin
            a = i[3:0];
            b = i[7:4];
            c = i[8];
            step(a, b, c, 1'b1);
            full = {1'b0, a} - {1'b0, b} - {4'd0, c};
            chk_res($sformatf("ex_%0d", i), full[3:0], full[4]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
